// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the 32-bit bus datapath.
// Decodes strobes from state plus the instruction latched when IRin fires.
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 255,
  parameter int COUNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic [31:0] ir,
  input  logic mem_ready,
  output logic PCout,
  output logic PCin,
  output logic IncPc,
  output logic MARin,
  output logic MDRin,
  output logic MDRout,
  output logic IRin,
  output logic Yin,
  output logic Zin,
  output logic Zlowout,
  output logic Zhighout,
  output logic HIin,
  output logic LOin,
  output logic Cout,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0] control,
  output logic read,
  output logic mem_req,
  output logic mem_we,
  output logic [31:0] c_sext,
  output logic halted,
  output logic fault,
  output logic illegal,
  output logic [COUNT_W-1:0] instr_count
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, HALT, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] ir_q;
  logic [WW-1:0] wcnt;
  logic [4:0] op_in, op;
  logic [3:0] ra, rb, rc;
  logic alu, imm, md, ld, st, legal_in, mem_wait, timeout;
  assign op_in = ir[31:27];
  assign op = ir_q[31:27];
  assign ra = ir_q[26:23];
  assign rb = ir_q[22:19];
  assign rc = ir_q[18:15];
  assign alu = op >= 5'd3 && op <= 5'd10;
  assign imm = op >= 5'd11 && op <= 5'd13;
  assign md = op == 5'd14 || op == 5'd15;
  assign ld = op == 5'd0;
  assign st = op == 5'd1;
  assign legal_in = op_in <= 5'd1 || (op_in >= 5'd3 && op_in <= 5'd15) || op_in == 5'd26 || op_in == 5'd27;
  assign mem_wait = state == T1 || (state == T6 && ld) || (state == T7 && st);
  assign timeout = mem_wait && !mem_ready && wcnt == WW'(MEM_WAIT_MAX - 1);
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign halted = state == HALT;
  assign fault = state == FAULT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ir_q <= '0;
      wcnt <= '0;
      illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      ir_q <= state == T2 ? ir : ir_q;
      wcnt <= state_n != state ? '0 : mem_wait ? wcnt + 1'b1 : wcnt;
      illegal <= state == T2 && !legal_in;
      instr_count <= state == DONE ? instr_count + 1'b1 : instr_count;
    end
  // The opcode is decoded straight off ir in T2, the cycle IR is being loaded.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = run ? T0 : IDLE;
      T0: state_n = T1;
      T1: state_n = mem_ready ? T2 : T1;
      T2: state_n = op_in == 5'd27 ? HALT : (op_in == 5'd26 || !legal_in) ? DONE : T3;
      T3: state_n = T4;
      T4: state_n = T5;
      T5: state_n = (alu || imm) ? DONE : T6;
      T6: state_n = (ld && !mem_ready) ? T6 : md ? DONE : T7;
      T7: state_n = (st && !mem_ready) ? T7 : DONE;
      DONE: state_n = run ? T0 : IDLE;
      default: state_n = state;
    endcase
    if (timeout) state_n = FAULT;
  end
  always_comb begin
    {PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout} = '0;
    Rin = '0;
    Rout = '0;
    control = '0;
    read = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    case (state)
      T0: {PCout, MARin, IncPc, Zin} = '1;
      T1: begin
        Zlowout = 1'b1;
        PCin = wcnt == '0;
        read = 1'b1;
        mem_req = 1'b1;
        MDRin = mem_ready;
      end
      T2: {MDRout, IRin} = '1;
      T3: begin
        Yin = 1'b1;
        Rout = 16'b1 << (md ? ra : rb);
      end
      T4: begin
        Zin = 1'b1;
        Cout = imm || ld || st;
        Rout = alu ? 16'b1 << rc : md ? 16'b1 << rb : 16'b0;
        control = alu ? 4'(op - 5'd3) : md ? {3'b100, op[0]} : op == 5'd12 ? 4'd2 : op == 5'd13 ? 4'd3 : 4'd0;
      end
      T5: begin
        Zlowout = 1'b1;
        Rin = (alu || imm) ? 16'b1 << ra : 16'b0;
        LOin = md;
        MARin = ld || st;
      end
      T6: begin
        Zhighout = md;
        HIin = md;
        read = ld;
        mem_req = ld;
        MDRin = ld ? mem_ready : st;
        Rout = st ? 16'b1 << ra : 16'b0;
      end
      T7: begin
        MDRout = ld;
        Rin = ld ? 16'b1 << ra : 16'b0;
        mem_req = st;
        mem_we = st;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction step-list model compared against the sequencer every cycle.
module tb_control_sequencer;
  localparam int MW = 4, CW = 3;
  localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, MDRIN = 4, MDROUT = 5, IRIN = 6;
  localparam int YIN = 7, ZIN = 8, ZLOW = 9, ZHIGH = 10, HIIN = 11, LOIN = 12, COUT = 13;
  typedef struct packed {
    logic [13:0] s;
    logic [15:0] rin, rout;
    logic [3:0] ctl;
    logic rd, req, we, hlt, flt, ill;
    logic [CW-1:0] cnt;
    logic [31:0] cs;
  } rec_t;
  logic clk = 1'b0, reset, run, mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout;
  logic [15:0] Rin, Rout;
  logic [3:0] control;
  logic read, mem_req, mem_we, halted, fault, illegal;
  logic [31:0] c_sext;
  logic [CW-1:0] instr_count;
  rec_t q[$];
  rec_t e, a;
  int tests = 0, fails = 0, dly = 0, rc = 0, st;
  bit tie = 0, never = 0;
  logic [CW-1:0] mcnt;
  logic [31:0] cur_ir;
  logic [13:0] act_s;
  control_sequencer #(.MEM_WAIT_MAX(MW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .Cout(Cout), .Rin(Rin), .Rout(Rout), .control(control), .read(read),
    .mem_req(mem_req), .mem_we(mem_we), .c_sext(c_sext), .halted(halted), .fault(fault),
    .illegal(illegal), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  // Memory responder: ready after dly cycles of continuous request.
  always @(posedge clk) rc <= mem_req ? rc + 1 : 0;
  assign mem_ready = tie | (mem_req & !never & (rc >= dly));
  assign act_s = {Cout, LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, MARin, IncPc, PCin, PCout};
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    e = q.pop_front();
    a = {act_s, Rin, Rout, control, read, mem_req, mem_we, halted, fault, illegal, instr_count, Cout ? c_sext : 32'h0};
    chk("cycle", a, e);
  end
  function automatic logic [13:0] sb(input int p, input int b = -1, input int c = -1, input int d = -1);
    sb = '0;
    if (p >= 0) sb[p] = 1'b1;
    if (b >= 0) sb[b] = 1'b1;
    if (c >= 0) sb[c] = 1'b1;
    if (d >= 0) sb[d] = 1'b1;
  endfunction
  function automatic logic [15:0] oh(input logic [3:0] r);
    oh = 16'b1 << r;
  endfunction
  task automatic push(input logic [13:0] s, input logic [15:0] rin = 0, input logic [15:0] rout = 0,
                      input logic [3:0] ctl = 0, input logic rd = 0, input logic req = 0, input logic we = 0,
                      input logic hlt = 0, input logic flt = 0, input logic ill = 0);
    q.push_back('{s, rin, rout, ctl, rd, req, we, hlt, flt, ill, mcnt,
                  s[COUT] ? {{13{cur_ir[18]}}, cur_ir[18:0]} : 32'h0});
  endtask
  task automatic access(input logic [13:0] s0, input bit pc_first, input bit rd, input bit we,
                        input bit mdr_last, input int d, input bit nr);
    int n = nr ? MW : d + 1;
    for (int k = 0; k < n; k++)
      push(s0 | ((k == 0 && pc_first) ? sb(PCIN) : 14'h0) | ((k == n - 1 && !nr && mdr_last) ? sb(MDRIN) : 14'h0),
           0, 0, 0, rd, 1'b1, we);
  endtask
  task automatic model(input logic [31:0] w, input int d, input bit nr, output int status);
    logic [4:0] op = w[31:27];
    logic [3:0] ra = w[26:23], rb = w[22:19], rc3 = w[18:15];
    bit alu = op >= 3 && op <= 10, imm = op >= 11 && op <= 13, md = op == 14 || op == 15;
    bit ld = op == 0, sto = op == 1;
    logic [3:0] ctl = alu ? 4'(op - 3) : imm ? (op == 11 ? 4'd0 : op == 12 ? 4'd2 : 4'd3) : md ? (op == 14 ? 4'd8 : 4'd9) : 4'd0;
    status = 0;
    cur_ir = w;
    push(sb(PCOUT, MARIN, INCPC, ZIN));
    access(sb(ZLOW), 1, 1, 0, 1, d, nr);
    if (nr) begin status = 2; return; end
    push(sb(MDROUT, IRIN));
    if (op == 27) begin status = 1; return; end
    if (alu || imm || md || ld || sto) begin
      push(sb(YIN), 0, oh(md ? ra : rb));
      push(sb(ZIN, (alu || md) ? -1 : COUT), 0, alu ? oh(rc3) : md ? oh(rb) : 16'h0, ctl);
      if (alu || imm) push(sb(ZLOW), oh(ra));
      else if (md) begin
        push(sb(ZLOW, LOIN));
        push(sb(ZHIGH, HIIN));
      end else begin
        push(sb(ZLOW, MARIN));
        if (ld) begin
          access(14'h0, 0, 1, 0, 1, d, 0);
          push(sb(MDROUT), oh(ra));
        end else begin
          push(sb(MDRIN), 0, oh(ra));
          access(14'h0, 0, 0, 1, 0, d, 0);
        end
      end
    end
    push(14'h0, 0, 0, 0, 0, 0, 0, 0, 0, !(alu || imm || md || ld || sto || op == 26));
    mcnt++;
  endtask
  task automatic begin_instr(input logic [31:0] w, input int d, input bit nr, output int status);
    @(posedge clk); #1;
    ir = w; dly = d; never = nr; run = 1'b1;
    push(14'h0);
    model(w, d, nr, status);
  endtask
  task automatic finish_instr;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    #1 chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; q.delete(); mcnt = '0; never = 0;
    #2 chk("reset_outputs", {act_s, Rin, Rout, control, read, mem_req, mem_we, halted, fault, illegal, instr_count}, 0);
    @(posedge clk); #1 reset = 1'b1;
  endtask
  initial begin
    int n, found;
    reset = 1'b0; run = 1'b0; ir = '0; mcnt = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", {act_s, Rin, Rout, control, read, mem_req, mem_we, halted, fault, illegal, instr_count}, 0);
    reset = 1'b1;
    tie = 1;
    begin_instr(32'h18D00000, 0, 0, st);
    chk("add_len", q.size(), 8);
    chk("add_t5_rin", q[6].rin, 16'h0002);
    chk("add_t4_ctl", {q[5].s[ZIN], q[5].ctl}, 5'h10);
    finish_instr;
    chk("add_count", instr_count, 1);
    tie = 0;
    begin_instr(32'h01180010, 3, 0, st);
    n = 0;
    foreach (q[i]) n += q[i].req;
    chk("ld_req_cycles", n, 8);
    chk("ld_t4_csext", {q[8].s[COUT], q[8].cs}, {1'b1, 32'h00000010});
    chk("ld_t7_rin", q[14].rin, 16'h0004);
    finish_instr;
    begin_instr(32'h0A2FFFFF, 3, 0, st);
    chk("st_len", q.size(), 16);
    chk("st_t4_csext", q[8].cs, 32'hFFFFFFFF);
    chk("st_t6", {q[10].rout, q[10].s[MDRIN], q[10].rd}, {16'h0010, 1'b1, 1'b0});
    chk("st_t7_we", {q[11].req, q[11].we}, 2'b11);
    finish_instr;
    begin_instr({5'd14, 4'd6, 4'd7, 19'd0}, 0, 0, st);
    n = 0;
    foreach (q[i]) n += (q[i].rin != 0);
    chk("mul_no_rin", n, 0);
    chk("mul_ctl_lo_hi", {q[5].ctl, q[6].s[LOIN], q[7].s[HIIN]}, {4'd8, 2'b11});
    finish_instr;
    begin_instr({5'd12, 4'd9, 4'd2, 19'h7FFFF}, 1, 0, st);
    chk("andi_ctl", q[6].ctl, 4'd2);
    finish_instr;
    for (int i = 0; i < 4; i++) begin
      begin_instr({5'd26, 27'd0}, 2, 0, st);
      finish_instr;
    end
    chk("count_wrap", instr_count, 1);
    begin_instr({5'd27, 27'd0}, 0, 0, st);
    chk("halt_status", st, 1);
    for (int i = 0; i < 5; i++) push(14'h0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 run = 1'b0;
    @(posedge clk); #1 run = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    #1 chk("halt_sticky", {halted, fault, q.size()}, {2'b10, 32'd0});
    do_reset;
    begin_instr({5'd31, 27'd0}, 0, 0, st);
    chk("illegal_model", {q.size(), q[4].ill}, {32'd5, 1'b1});
    finish_instr;
    chk("illegal_count", instr_count, 1);
    begin_instr(32'h18D00000, 0, 1, st);
    n = 0;
    foreach (q[i]) n += q[i].req;
    chk("fault_wait_cycles", n, MW);
    for (int i = 0; i < 3; i++) push(14'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 run = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    #1 chk("fault_sticky", {fault, halted, q.size()}, {2'b10, 32'd0});
    do_reset;
    begin_instr({5'd26, 27'd0}, 0, 0, st);
    finish_instr;
    begin_instr(32'h01180010, 3, 0, st);
    @(posedge clk); #1 run = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = int'(mem_req && !Zlowout);
    end
    chk("midreset_reach_t6", found, 1);
    #1 reset = 1'b0;
    #1 chk("midreset_async", {mem_req, read, instr_count}, 0);
    q.delete(); mcnt = '0;
    @(posedge clk); #1 reset = 1'b1;
    begin_instr(32'h18D00000, 0, 0, st);
    finish_instr;
    chk("recover_count", instr_count, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
